nareg_fetch_queue: RTL and testbench
====================================

# nareg_fetch_queue

Parametrised instruction/PC capture queue that replaces the single-entry instruction register in the fetch path. Each accepted fetch stores an {instruction, PC} pair; the head pair is presented to decode as Instr/OldPC until decode consumes it. It provides a DEPTH-entry FIFO with valid/ready handshakes on both sides, a flush for taken branches/jumps, and an occupancy count.

## Interface
Parameters:
- XLEN, 32, width of instruction and PC fields
- DEPTH, 4, number of entries; power of two, ≥ 2
- NOP_INSTR, 32'h00000013, value driven on Instr while the queue is empty (addi x0,x0,0)

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch data (memory RD) valid this cycle
- in_ready  out  1  queue can accept; equals (count != DEPTH)
- in_instr  in  XLEN  fetched instruction word
- in_pc  in  XLEN  PC the word was fetched from
- flush  in  1  discard all entries (redirect)
- out_valid  out  1  head entry present; equals (count != 0)
- out_ready  in  1  decode consumes head this cycle (IRWrite equivalent)
- Instr  out  XLEN  head instruction, NOP_INSTR when empty
- OldPC  out  XLEN  head PC, 0 when empty
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- push writes {in_instr, in_pc} at wr_ptr, wr_ptr increments modulo DEPTH.
- pop advances rd_ptr modulo DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: in_ready=0; push refused even if pop occurs same cycle (no full-bypass).
- Empty: out_valid=0; no write-through bypass, so a pushed entry appears at the output the next cycle.
- Instr/OldPC: combinational read of entry at rd_ptr, masked to NOP_INSTR/0 when count==0.
- flush: next cycle wr_ptr=rd_ptr=0, count=0; same-cycle push and pop have no effect; flush dominates all other inputs.
- Entries are never reordered or duplicated; FIFO order is strict.
- Storage array is not reset; only pointers and count are reset. Outputs stay defined through the empty mask.

## Timing
- Reset (async assert, sync release on clk): wr_ptr=0, rd_ptr=0, count=0 → out_valid=0, in_ready=1, Instr=NOP_INSTR, OldPC=0, all immediately on rst assertion.
- Reset mid-operation discards all entries; the first push after release appears at the output one cycle later.
- Push-to-output latency: 1 cycle (accepted at edge N, visible after edge N).
- Pop effect: the next head is visible immediately after the edge on which the pop occurred.
- Flush latency: 1 edge; outputs show empty/NOP after that edge.
- Pointer wrap: DEPTH-1 → 0 with no bubble.
- in_ready, out_valid and count depend only on registered state, never on same-cycle inputs.

## Structure
- Shared package nareg_pkg: NOP_INSTR constant and typedef fetch_entry_t (packed struct {instr, pc}, each XLEN). The module uses the package-level default for NOP_INSTR.
- Pointers are $clog2(DEPTH) bits. count is held as a separate register rather than derived from pointer difference.
- No sub-module required. Storage is an inline array of fetch_entry_t[DEPTH] with pointer/count control in one always_ff.

## Test plan
- Reset: assert rst mid-stream with 3 entries held → count=0, out_valid=0, in_ready=1, Instr=0x00000013, OldPC=0 before the next clk edge.
- Single pass: push {0x00500093, 0x0} → next cycle out_valid=1, Instr=0x00500093, OldPC=0. Pop → empty, Instr=NOP.
- Fill/full: DEPTH=4, push PCs 0x0/0x4/0x8/0xC → count=4, in_ready=0. A 5th push with simultaneous pop is refused: count=3, head OldPC=0x4.
- Wrap: after 6 pushes and 6 interleaved pops, output order of OldPC is 0x0..0x14 with no gaps or duplicates.
- Simultaneous push/pop at count=2 → count stays 2, head advances, and the new entry is the tail.
- Flush with push and pop asserted at count=3 → next cycle count=0, out_valid=0. The pushed word never appears. The following push of {0x00A00113, 0x40} is output next cycle.

Source files
------------

// File: rtl/nareg_pkg.sv
// nareg_pkg: shared definitions for the fetch-path instruction/PC queue.
//   XLEN          : width of the instruction and PC fields in a queue entry
//   NOP_INSTR     : word shown to decode while no fetch is held (addi x0,x0,0)
//   fetch_entry_t : one captured fetch, {instr, pc}
package nareg_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/nareg_fetch_queue.sv
// nareg_fetch_queue: DEPTH-entry FIFO of {instruction, PC} pairs sitting
// between instruction fetch and decode, replacing the single instruction
// register. The head pair is presented as Instr/OldPC until decode takes it.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   fetch side handshake; in_ready = not full
//   in_instr, in_pc     fetched word and the PC it came from
//   flush               drop every held entry (taken branch / jump redirect)
//   out_valid/out_ready decode side handshake; out_valid = not empty
//   Instr, OldPC        head entry; NOP_INSTR / 0 while empty
//   count               current occupancy, 0..DEPTH
//
// XLEN must match the field width of nareg_pkg::fetch_entry_t.
module nareg_fetch_queue #(
  parameter int              XLEN      = nareg_pkg::XLEN,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = nareg_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_instr,
  input  logic [XLEN-1:0]            in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            Instr,
  output logic [XLEN-1:0]            OldPC,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import nareg_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t        mem [DEPTH];
  fetch_entry_t        head;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                push, pop;

  // Handshake flags come from registered count only, never from inputs.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);

  // Flush cancels any same-cycle transfer; full refuses a push even when a
  // pop happens on the same edge.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Storage carries no reset; the empty mask below keeps outputs defined.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // No write-through: a fresh entry is only visible after its write edge.
  assign head  = mem[rd_ptr];
  assign Instr = out_valid ? head.instr : NOP_INSTR;
  assign OldPC = out_valid ? head.pc    : '0;

endmodule

// File: tb/tb_nareg_fetch_queue.sv
module tb_nareg_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] in_instr = '0, in_pc = '0, Instr, OldPC;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the queue contents as an ordered list of {instr, pc}.
  logic [63:0] q[$];

  nareg_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .Instr(Instr), .OldPC(OldPC), .count(count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus: drive at negedge, model the edge, return at negedge.
  task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] p,
                     input logic r, input logic f);
    bit ph, pp;
    in_valid = v; in_instr = i; in_pc = p; out_ready = r; flush = f;
    ph = v && (q.size() < DEPTH) && !f;
    pp = r && (q.size() != 0) && !f;
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (ph) q.push_back({i, p});
    end
    @(negedge clk);
    in_valid = 0; out_ready = 0; flush = 0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (count !== 0 || out_valid !== 0 || in_ready !== 1 || Instr !== NOP || OldPC !== 0) begin
      n_bad++;
      $display("FAIL reset_initial: cnt=%0d ov=%b ir=%b Instr=%h OldPC=%h, want 0/0/1/%h/0",
               count, out_valid, in_ready, Instr, OldPC, NOP);
    end
    @(negedge clk); rst = 0; @(negedge clk);
    cyc(1, 32'h1111_0001, 32'h100, 0, 0);
    cyc(1, 32'h1111_0002, 32'h104, 0, 0);
    cyc(1, 32'h1111_0003, 32'h108, 0, 0);
    n_cmp++;
    if (count !== 3) begin
      n_bad++; $display("FAIL reset_prefill: count=%0d want 3", count);
    end
    // Assert mid-cycle; outputs must clear before the next edge.
    #2 rst = 1; #1;
    n_cmp++;
    if (count !== 0 || out_valid !== 0 || in_ready !== 1 || Instr !== NOP || OldPC !== 0) begin
      n_bad++;
      $display("FAIL reset_async: cnt=%0d ov=%b ir=%b Instr=%h OldPC=%h, want 0/0/1/%h/0",
               count, out_valid, in_ready, Instr, OldPC, NOP);
    end
    q.delete();
    @(negedge clk); rst = 0;
    cyc(1, 32'h2222_0001, 32'h200, 0, 0);
    n_cmp++;
    if (out_valid !== 1 || Instr !== 32'h2222_0001 || OldPC !== 32'h200) begin
      n_bad++;
      $display("FAIL reset_first_push: ov=%b Instr=%h OldPC=%h want 1/22220001/200",
               out_valid, Instr, OldPC);
    end
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic test_single();
    cyc(1, 32'h0050_0093, 32'h0, 0, 0);
    n_cmp++;
    if (out_valid !== 1 || Instr !== 32'h0050_0093 || OldPC !== 0 || count !== 1) begin
      n_bad++;
      $display("FAIL single_push: ov=%b Instr=%h OldPC=%h cnt=%0d want 1/00500093/0/1",
               out_valid, Instr, OldPC, count);
    end
    cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if (out_valid !== 0 || Instr !== NOP || OldPC !== 0 || count !== 0) begin
      n_bad++;
      $display("FAIL single_pop: ov=%b Instr=%h OldPC=%h cnt=%0d want 0/%h/0/0",
               out_valid, Instr, OldPC, count, NOP);
    end
  endtask

  task automatic test_fill_full();
    for (int k = 0; k < 4; k++) cyc(1, 32'hA000_0000 + k, 32'(k * 4), 0, 0);
    n_cmp++;
    if (count !== 4 || in_ready !== 0) begin
      n_bad++; $display("FAIL full: cnt=%0d ir=%b want 4/0", count, in_ready);
    end
    cyc(1, 32'hDEAD_BEEF, 32'h10, 1, 0);
    n_cmp++;
    if (count !== 3 || OldPC !== 32'h4 || Instr !== 32'hA000_0001 || in_ready !== 1) begin
      n_bad++;
      $display("FAIL full_refuse: cnt=%0d OldPC=%h Instr=%h ir=%b want 3/4/a0000001/1",
               count, OldPC, Instr, in_ready);
    end
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if (count !== 0) begin
      n_bad++; $display("FAIL full_drain: cnt=%0d want 0", count);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    cyc(1, 32'hB000_0000, 32'h0, 0, 0);
    for (int k = 1; k < 6; k++) begin
      seen.push_back(OldPC);
      cyc(1, 32'hB000_0000 + k, 32'(k * 4), 1, 0);
    end
    seen.push_back(OldPC);
    cyc(0, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (seen[k] !== 32'(k * 4)) begin
        n_bad++; $display("FAIL wrap_order[%0d]: OldPC=%h want %h", k, seen[k], k * 4);
      end
    end
    n_cmp++;
    if (out_valid !== 0) begin
      n_bad++; $display("FAIL wrap_empty: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 32'hC000_0001, 32'h300, 0, 0);
    cyc(1, 32'hC000_0002, 32'h304, 0, 0);
    cyc(1, 32'hC000_0003, 32'h308, 1, 0);
    n_cmp++;
    if (count !== 2 || OldPC !== 32'h304 || Instr !== 32'hC000_0002) begin
      n_bad++;
      $display("FAIL simul_pushpop: cnt=%0d OldPC=%h Instr=%h want 2/304/c0000002",
               count, OldPC, Instr);
    end
    cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if (count !== 1 || OldPC !== 32'h308) begin
      n_bad++; $display("FAIL simul_tail: cnt=%0d OldPC=%h want 1/308", count, OldPC);
    end
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) cyc(1, 32'hE000_0000 + k, 32'h500 + 32'(k * 4), 0, 0);
    cyc(1, 32'hBAD0_BAD0, 32'h999, 1, 1);
    n_cmp++;
    if (count !== 0 || out_valid !== 0 || Instr !== NOP || OldPC !== 0) begin
      n_bad++;
      $display("FAIL flush: cnt=%0d ov=%b Instr=%h OldPC=%h want 0/0/%h/0",
               count, out_valid, Instr, OldPC, NOP);
    end
    cyc(1, 32'h00A0_0113, 32'h40, 0, 0);
    n_cmp++;
    if (count !== 1 || Instr !== 32'h00A0_0113 || OldPC !== 32'h40) begin
      n_bad++;
      $display("FAIL flush_after: cnt=%0d Instr=%h OldPC=%h want 1/00a00113/40",
               count, Instr, OldPC);
    end
    cyc(0, 0, 0, 1, 0);
    n_cmp++;
    if (out_valid !== 0) begin
      n_bad++; $display("FAIL flush_drain: ov=%b want 0 (flushed word resurfaced?)", out_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] ei, ep;
    int          bad_here;
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom, $urandom,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
      ei = (q.size() != 0) ? q[0][63:32] : NOP;
      ep = (q.size() != 0) ? q[0][31:0]  : 32'h0;
      bad_here = 0;
      n_cmp++;
      if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) ||
          in_ready !== (q.size() != DEPTH) || Instr !== ei || OldPC !== ep) begin
        n_bad++;
        bad_here = 1;
      end
      if (bad_here != 0)
        $display("FAIL random[%0d]: cnt=%0d ov=%b ir=%b Instr=%h OldPC=%h want %0d/%b/%b/%h/%h",
                 n, count, out_valid, in_ready, Instr, OldPC,
                 q.size(), (q.size() != 0), (q.size() != DEPTH), ei, ep);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_fill_full();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
